// File: rtl/gemm_stream_sequencer.sv
// gemm_stream_sequencer
// Job-level controller in front of a fixed-weight systolic GEMM array that
// has no stall input. For each job it clears the array for one cycle, then
// streams num_vectors activation vectors from a valid/ready source. Cycles
// where the source has no vector are filled with zero vectors. Every array
// slot is tagged so that only real results reach the result port. After the
// last result it pulses done.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   start, num_vectors    job start pulse (IDLE only) and vector count
//   busy, done            job in progress / one-cycle end-of-job pulse
//   act_in_valid/ready/data  activation source (valid/ready)
//   gemm_resetn           array reset, active-low (low in CLEAR or on resetn)
//   gemm_act              vector to the array, zero when no handshake
//   gemm_act_out          vector back from the array
//   res_valid/data/last   result stream with no backpressure
//
// Optional feature (define GEMM_SEQ_PERF_EN):
//   bubble_cycles         saturating count of FEED cycles with no source vector
//   job_cycles            saturating count of cycles from CLEAR through DONE
module gemm_stream_sequencer #(
  parameter int unsigned SA_SIZE                = 4,
  parameter int unsigned WEIGHT_ACTIVATION_SIZE = 8,
  parameter int unsigned PIPE_LATENCY           = 2 * SA_SIZE,
  parameter int unsigned MAX_VECTORS            = 256,
  parameter int unsigned CNT_W                  = $clog2(MAX_VECTORS + 1)
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      start,
  input  logic [CNT_W-1:0]                          num_vectors,
  output logic                                      busy,
  output logic                                      done,
  input  logic                                      act_in_valid,
  output logic                                      act_in_ready,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] act_in_data,
  output logic                                      gemm_resetn,
  output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] gemm_act,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] gemm_act_out,
  output logic                                      res_valid,
  output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] res_data,
  output logic                                      res_last
`ifdef GEMM_SEQ_PERF_EN
  ,
  output logic [31:0]                               bubble_cycles,
  output logic [31:0]                               job_cycles
`endif
);

  localparam int unsigned VEC_W = SA_SIZE * WEIGHT_ACTIVATION_SIZE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        accepted;
  logic [CNT_W-1:0]        emitted;
  logic [PIPE_LATENCY-1:0] tag;
  logic [PIPE_LATENCY-1:0] tag_nxt;
  logic                    hs;
  logic                    last_accept;

  assign hs          = act_in_valid & act_in_ready;
  assign last_accept = (accepted + CNT_W'(1)) == count;
  // Tag bit 0 records whether the slot entering the array this cycle is real.
  assign tag_nxt     = (tag << 1) | PIPE_LATENCY'(hs);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = (count == '0) ? S_DONE : S_FEED;
      S_FEED:  if (hs && last_accept) state_nxt = S_DRAIN;
      // Looking at the next tag value lets DONE follow the last result directly.
      S_DRAIN: if (tag_nxt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded control outputs
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    act_in_ready = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_CLEAR: busy = 1'b1;
      S_FEED:  begin busy = 1'b1; act_in_ready = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  // Job count, handshake/result counters and slot tags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count    <= '0;
      accepted <= '0;
      emitted  <= '0;
      tag      <= '0;
    end else begin
      tag <= tag_nxt;
      if (state == S_IDLE && start) count <= num_vectors;
      if (state == S_CLEAR) begin
        accepted <= '0;
        emitted  <= '0;
      end else begin
        if (hs)        accepted <= accepted + CNT_W'(1);
        if (res_valid) emitted  <= emitted + CNT_W'(1);
      end
    end
  end

  assign gemm_resetn = resetn & (state != S_CLEAR);
  assign gemm_act    = hs ? act_in_data : VEC_W'(0);
  assign res_valid   = tag[PIPE_LATENCY-1];
  assign res_data    = res_valid ? gemm_act_out : VEC_W'(0);
  assign res_last    = res_valid & (emitted == (count - CNT_W'(1)));

`ifdef GEMM_SEQ_PERF_EN
  // Performance counters: cleared on CLEAR entry, held once the job ends
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bubble_cycles <= '0;
      job_cycles    <= '0;
    end else if (state == S_IDLE && start) begin
      bubble_cycles <= '0;
      job_cycles    <= '0;
    end else begin
      if (state != S_IDLE && job_cycles != '1)
        job_cycles <= job_cycles + 32'd1;
      if (state == S_FEED && !act_in_valid && bubble_cycles != '1)
        bubble_cycles <= bubble_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_stream_sequencer.sv
// Testbench for gemm_stream_sequencer: randomized jobs against an ordered
// expected-result scoreboard, plus cycle-exact checks of the job timeline.
module tb_gemm_stream_sequencer;

  localparam int unsigned SA   = 4;
  localparam int unsigned WAS  = 8;
  localparam int unsigned PL   = 2 * SA;
  localparam int unsigned MAXV = 256;
  localparam int unsigned CW   = $clog2(MAXV + 1);
  localparam int unsigned VW   = SA * WAS;
  localparam logic [VW-1:0] KEY = VW'(32'h5A3C_96E1);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_vectors = '0;
  logic          busy, done;
  logic          act_in_valid = 1'b0;
  logic          act_in_ready;
  logic [VW-1:0] act_in_data = '0;
  logic          gemm_resetn;
  logic [VW-1:0] gemm_act, gemm_act_out;
  logic          res_valid, res_last;
  logic [VW-1:0] res_data;
`ifdef GEMM_SEQ_PERF_EN
  logic [31:0]   bubble_cycles, job_cycles;
`endif

  gemm_stream_sequencer #(
    .SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(WAS), .PIPE_LATENCY(PL), .MAX_VECTORS(MAXV)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .num_vectors(num_vectors),
    .busy(busy), .done(done),
    .act_in_valid(act_in_valid), .act_in_ready(act_in_ready), .act_in_data(act_in_data),
    .gemm_resetn(gemm_resetn), .gemm_act(gemm_act), .gemm_act_out(gemm_act_out),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last)
`ifdef GEMM_SEQ_PERF_EN
    , .bubble_cycles(bubble_cycles), .job_cycles(job_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in array: fixed PL-cycle delay with a recognisable transform, cleared by gemm_resetn.
  logic [VW-1:0] pipe [PL];
  always @(posedge clk) begin
    if (!gemm_resetn) begin
      for (int i = 0; i < PL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= gemm_act;
      for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign gemm_act_out = pipe[PL-1] ^ KEY;

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [VW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   res_rel_q[$];
  int   hs_rel_q[$];
  int   clear_rel, done_rel, done_cnt, busyfall_rel;

  // Monitor: pops the scoreboard whenever a result is presented.
  always @(negedge clk) begin : mon
    int   rel;
    exp_t e;
    rel = cyc - t0;
    if (resetn) begin
      if (!gemm_resetn && clear_rel < 0) clear_rel = rel;
      if (act_in_valid && act_in_ready) begin
        hs_rel_q.push_back(rel);
        chk("gemm_act_pass", 64'(gemm_act), 64'(act_in_data));
      end else begin
        chk("gemm_act_zero", 64'(gemm_act), 64'd0);
      end
      if (res_valid) begin
        res_rel_q.push_back(rel);
        if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("res_data", 64'(res_data), 64'(e.data));
          chk("res_last", 64'(res_last), 64'(e.last));
        end
      end else begin
        chk("res_last_idle", 64'(res_last), 64'd0);
        chk("res_data_idle", 64'(res_data), 64'd0);
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
      if (done_cnt > 0 && !busy && busyfall_rel < 0) busyfall_rel = rel;
    end
  end

  // mode: 0 = source always valid, 1 = bubble at job cycle 3 only, 2 = random bubbles.
  task automatic run_job(input int n, input int mode, input int abort_rel, input bit start_in_feed);
    logic [VW-1:0] vecs[$];
    int idx, guard, rel;
    bit v, hs;
    for (int i = 0; i < n; i++) vecs.push_back(VW'($urandom));
    @(posedge clk); #1;
    t0 = cyc;
    clear_rel = -1; done_rel = -1; done_cnt = 0; busyfall_rel = -1;
    res_rel_q.delete(); hs_rel_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back('{data: vecs[i] ^ KEY, last: (i == n - 1)});
    start = 1'b1;
    num_vectors = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    num_vectors = CW'($urandom);
    idx = 0;
    guard = 0;
    while (idx < n && guard < 3000) begin
      rel = cyc - t0;
      if (abort_rel >= 0 && rel == abort_rel) begin
        act_in_valid = 1'b0;
        resetn = 1'b0;
        #1 chk("gemm_resetn_abort", 64'(gemm_resetn), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        exp_q.delete();
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (rel != 3);
        default: v = ($urandom_range(3) != 0);
      endcase
      act_in_valid = v;
      act_in_data  = v ? vecs[idx] : VW'($urandom);
      if (start_in_feed && rel == 3) begin
        start = 1'b1;
        num_vectors = CW'(n + 2);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hs = act_in_valid && act_in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    act_in_valid = 1'b0;
    start = 1'b0;
    if (guard >= 3000) chk("feed_timeout", 64'd1, 64'd0);
    if (abort_rel >= 0) begin
      repeat (30) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_no_result", 64'(res_rel_q.size()), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end else begin
      guard = 0;
      while ((done_cnt == 0 || busy) && guard < 400) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 400) chk("done_timeout", 64'd1, 64'd0);
      @(negedge clk); #1;
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("results_outstanding", 64'(exp_q.size()), 64'd0);
      chk("result_count", 64'(res_rel_q.size()), 64'(n));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_rel = -1; done_rel = -1; done_cnt = 0; busyfall_rel = -1;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(act_in_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_last", 64'(res_last), 64'd0);
    chk("rst_gemm_resetn", 64'(gemm_resetn), 64'd0);
`ifdef GEMM_SEQ_PERF_EN
    chk("rst_bubble_cycles", 64'(bubble_cycles), 64'd0);
    chk("rst_job_cycles", 64'(job_cycles), 64'd0);
`endif
    @(posedge clk); #1;
    resetn = 1'b1;

    // Three vectors, source always valid
    run_job(3, 0, -1, 1'b0);
    chk("t3_clear_cycle", 64'(clear_rel), 64'd1);
    chk("t3_hs_count", 64'(hs_rel_q.size()), 64'd3);
    chk("t3_first_hs", 64'(hs_rel_q[0]), 64'd2);
    chk("t3_last_hs", 64'(hs_rel_q[2]), 64'd4);
    chk("t3_first_res", 64'(res_rel_q[0]), 64'd10);
    chk("t3_last_res", 64'(res_rel_q[2]), 64'd12);
    chk("t3_done_cycle", 64'(done_rel), 64'd13);
    chk("t3_busy_low", 64'(busyfall_rel), 64'd14);

    // Two vectors with one source bubble
    run_job(2, 1, -1, 1'b0);
    chk("t2_res0", 64'(res_rel_q[0]), 64'd10);
    chk("t2_res1", 64'(res_rel_q[1]), 64'd12);
    chk("t2_done_cycle", 64'(done_rel), 64'd13);
`ifdef GEMM_SEQ_PERF_EN
    chk("t2_bubble_cycles", 64'(bubble_cycles), 64'd1);
    chk("t2_job_cycles", 64'(job_cycles), 64'd13);
`endif

    // Empty job
    run_job(0, 0, -1, 1'b0);
    chk("t0_clear_cycle", 64'(clear_rel), 64'd1);
    chk("t0_done_cycle", 64'(done_rel), 64'd2);

    // Reset in the middle of a four-vector job, then a clean job
    run_job(4, 0, 5, 1'b0);
    run_job(4, 2, -1, 1'b0);

    // Start pulse during FEED must be ignored
    run_job(5, 0, -1, 1'b1);

    // Randomized jobs, then the largest legal job
    for (int k = 0; k < 10; k++) run_job(int'($urandom_range(12, 1)), 2, -1, 1'($urandom_range(1)));
    run_job(MAXV, 2, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gemm_stream_sequencer.md
Name: gemm_stream_sequencer

Overview:
- Job-level controller in front of GEMM_Fixed_Weights_Each_Cycle (fixed-weight systolic array, one activation vector per cycle, no stall input).
- Per job: clears the array, streams a programmed number of activation vectors from a valid/ready source, and fills source bubbles with zero vectors.
- Tags every slot so only real results are emitted on a non-backpressured result port, then signals completion.

Parameters:
- SA_SIZE, 4, array dimension (vector lanes).
- WEIGHT_ACTIVATION_SIZE, 8, bits per lane.
- PIPE_LATENCY, 2*SA_SIZE, cycles from gemm_act to the matching gemm_act_out; must be >= 1.
- MAX_VECTORS, 256, largest num_vectors; CNT_W = $clog2(MAX_VECTORS+1).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  job start pulse, sampled in IDLE only.
- num_vectors  in  CNT_W  vectors in job, sampled with start.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at job end.
- act_in_valid  in  1  source vector valid.
- act_in_ready  out  1  sequencer accepts vector.
- act_in_data  in  SA_SIZE*WEIGHT_ACTIVATION_SIZE  lane i at bits [i*W +: W].
- gemm_resetn  out  1  array reset, active-low.
- gemm_act  out  SA_SIZE*WEIGHT_ACTIVATION_SIZE  to array activation_inputs.
- gemm_act_out  in  SA_SIZE*WEIGHT_ACTIVATION_SIZE  from array activation_outputs.
- res_valid  out  1  result vector valid; no backpressure.
- res_data  out  SA_SIZE*WEIGHT_ACTIVATION_SIZE  result vector.
- res_last  out  1  qualifies the job's final result.

Behaviour:
- One clock; synchronous active-low resetn on clk.
- Reset values: state IDLE, busy 0, done 0, act_in_ready 0, res_valid 0, res_last 0, tag shift register all 0, counters 0.
- gemm_resetn = resetn AND (state != CLEAR). Reset mid-job aborts the job: no done, no further res_valid.
- gemm_act = act_in_data when (act_in_valid AND act_in_ready), otherwise all-zero.
- States:
  - IDLE: start=1 latches num_vectors and goes to CLEAR; start in any other state is ignored.
  - CLEAR: exactly 1 cycle. If latched count = 0, go to DONE; otherwise go to FEED.
  - FEED: act_in_ready=1. Each handshake increments accepted. The handshake that makes accepted = count goes to DRAIN.
  - DRAIN: act_in_ready=0. When the tag register is all-zero, go to DONE.
  - DONE: done=1 for 1 cycle, busy=1, then IDLE.
- Tag register: PIPE_LATENCY bits. Bit 0 is loaded with the handshake flag every cycle; it shifts in all states and is cleared only by resetn.
  - res_valid = msb tag bit.
  - res_data = gemm_act_out when res_valid, else 0 (combinational pass-through).
- Emitted counter increments on res_valid. res_last = res_valid AND (emitted = count-1).
- Count > MAX_VECTORS is a usage error; behaviour is undefined.
- Latency: a vector accepted in cycle t gives res_valid in cycle t+PIPE_LATENCY.
- Consecutive jobs: the array is re-cleared in CLEAR, so no state carries over between jobs.

Optional Feature:
- Macro: GEMM_SEQ_PERF_EN.
- Defined: adds output bubble_cycles (32 bits, saturating) and output job_cycles (32 bits, saturating).
  - bubble_cycles counts FEED cycles with act_in_valid=0.
  - job_cycles counts cycles from CLEAR through DONE inclusive.
  - Both clear on entry to CLEAR, hold after DONE, and reset to 0.
- Undefined: neither port nor its logic exists.

Test Plan:
- SA_SIZE=4, PIPE_LATENCY=8, num_vectors=3, valid always high, start at cycle 0:
  - CLEAR at cycle 1 with gemm_resetn=0; handshakes at cycles 2-4.
  - res_valid at cycles 10-12, res_last at cycle 12, done at cycle 13, busy low at cycle 14.
- num_vectors=2 with act_in_valid low at cycle 3 only:
  - gemm_act=0 at cycle 3; results at cycles 10 and 12; res_valid=0 at cycle 11.
- num_vectors=0 -> CLEAR, then done pulse at cycle 2; res_valid never asserted.
- resetn low at cycle 5 of a 4-vector job:
  - gemm_resetn=0 and the tag register clears; no res_valid and no done afterwards.
  - A new job then completes normally.
- start pulsed during FEED -> ignored; the current job's result count is unchanged.
- With GEMM_SEQ_PERF_EN, the bubble case above -> bubble_cycles=1, job_cycles=13.
